// File: rtl/fetch_queue_pkg.sv
// Shared widths and sizing for the fetch queue (memi address/instruction widths, queue depth).
package fetch_queue_pkg;

  localparam int MEMI_SIZE_LOG = 8;
  localparam int INST_LEN      = 32;
  localparam int FETCHQ_DEPTH  = 4;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH x W synchronous FIFO with push/pop/flush and occupancy count.
// Latency: written data is readable at the head the cycle after the push; caller must not push when full or pop when empty.
// Backpressure: none internally; full/empty are exported so the wrapper can gate push/pop.
module fetchq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage is deliberately left unreset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == (PW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, drives memi and buffers {pc, inst} for decode; FETCHQ_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle fetch-to-deq (0 cycles when empty with FETCHQ_BYPASS_EN); redirect/reset flush everything.
// Backpressure: deq_ready low lets the queue fill to DEPTH, after which fetch and the PC stall.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [MEMI_SIZE_LOG-1:0]   imem_addr,
  input  logic [INST_LEN-1:0]        imem_data,
  input  logic                       redirect_valid,
  input  logic [MEMI_SIZE_LOG-1:0]   redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [MEMI_SIZE_LOG-1:0]   deq_pc,
  output logic [INST_LEN-1:0]        deq_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int EW = MEMI_SIZE_LOG + INST_LEN;

  logic [MEMI_SIZE_LOG-1:0] pc;
  logic [EW-1:0]            head_data;
  logic [$clog2(DEPTH):0]   q_count;
  logic                     q_empty;
  logic                     q_full;
  logic                     advance;
  logic                     take;
  logic                     push;
  logic                     pop;

  // A fetch happens whenever there is room and no squash; the fetched word
  // either enters storage or, with bypass, goes straight to the consumer.
  assign advance = !redirect_valid && !q_full;
  assign push    = advance && !take;
  assign pop     = !redirect_valid && !q_empty && deq_ready;

  always_ff @(posedge clk) begin
    if (rst)                 pc <= '0;
    else if (redirect_valid) pc <= redirect_pc;
    else if (advance)        pc <= pc + 1'b1;
  end

  fetchq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc, imem_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

`ifdef FETCHQ_BYPASS_EN
  logic bypass;

  assign bypass = q_empty && !redirect_valid;
  assign take   = bypass && deq_ready;

  always_comb begin
    deq_valid = !q_empty;
    deq_pc    = '0;
    deq_inst  = '0;
    if (bypass) begin
      deq_valid = 1'b1;
      deq_pc    = pc;
      deq_inst  = imem_data;
    end else if (!q_empty) begin
      {deq_pc, deq_inst} = head_data;
    end
  end
`else
  assign take = 1'b0;

  always_comb begin
    deq_valid = !q_empty;
    deq_pc    = '0;
    deq_inst  = '0;
    if (!q_empty) {deq_pc, deq_inst} = head_data;
  end
`endif

  assign imem_addr = pc;
  assign count     = q_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build, no bypass) with a PC/occupancy model and expected-PC scoreboard.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = MEMI_SIZE_LOG;
  localparam int IW    = INST_LEN;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [AW-1:0] deq_pc;
  logic [IW-1:0] deq_inst;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] m_pc = '0;
  int            m_count = 0;
  logic [AW-1:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
    return IW'(32'h5A00_0000 ^ (32'(a) * 32'h0001_0103));
  endfunction

  assign imem_data = inst_of(imem_addr);

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_inst       (deq_inst),
    .count          (count)
  );

  // One clock of stimulus: drive at negedge, compare against model, advance model at posedge.
  task automatic cycle(input bit rst_v, input bit rdy, input bit redir, input logic [AW-1:0] rpc);
    bit            popped;
    bit            pushed;
    logic [AW-1:0] exp_pc;
    @(negedge clk);
    rst = rst_v;
    deq_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    popped = 1'b0;
    if (!rst_v) begin
      n_checks++;
      if (deq_valid !== (m_count != 0)) $display("FAIL sb_valid: got %0b expected %0b", deq_valid, (m_count != 0));
      else n_pass++;
      n_checks++;
      if (count !== CW'(m_count)) $display("FAIL sb_count: got %0d expected %0d", count, m_count);
      else n_pass++;
      n_checks++;
      if (imem_addr !== m_pc) $display("FAIL sb_imem_addr: got %0h expected %0h", imem_addr, m_pc);
      else n_pass++;
      if (m_count != 0 && rdy && !redir && sb.size() > 0) begin
        exp_pc = sb.pop_front();
        popped = 1'b1;
        n_checks++;
        if (deq_pc !== exp_pc) $display("FAIL sb_deq_pc: got %0h expected %0h", deq_pc, exp_pc);
        else n_pass++;
        n_checks++;
        if (deq_inst !== inst_of(exp_pc)) $display("FAIL sb_deq_inst: got %0h expected %0h", deq_inst, inst_of(exp_pc));
        else n_pass++;
      end
    end
    @(posedge clk);
    if (rst_v) begin
      sb.delete();
      m_count = 0;
      m_pc = '0;
    end else if (redir) begin
      sb.delete();
      m_count = 0;
      m_pc = rpc;
    end else begin
      pushed = (m_count < DEPTH);
      if (pushed) begin
        sb.push_back(m_pc);
        m_pc = m_pc + 1'b1;
      end
      m_count = m_count + int'(pushed) - int'(popped);
    end
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (deq_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", deq_valid); else n_pass++;
    n_checks++;
    if (deq_pc !== '0) $display("FAIL reset_deq_pc: got %0h expected 0", deq_pc); else n_pass++;
    n_checks++;
    if (deq_inst !== '0) $display("FAIL reset_deq_inst: got %0h expected 0", deq_inst); else n_pass++;
    n_checks++;
    if (imem_addr !== '0) $display("FAIL reset_imem_addr: got %0h expected 0", imem_addr); else n_pass++;
    n_checks++;
    if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 0, '0);
      #1;
      e = AW'(k);
      n_checks++;
      if (deq_valid !== 1'b1 || deq_pc !== e) $display("FAIL stream_pc: got v=%0b pc=%0h expected v=1 pc=%0h", deq_valid, deq_pc, e);
      else n_pass++;
      n_checks++;
      if (count !== CW'(1)) $display("FAIL stream_count: got %0d expected 1", count); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] e;
    do_reset();
    repeat (10) cycle(0, 0, 0, '0);
    #1;
    n_checks++;
    if (count !== CW'(DEPTH)) $display("FAIL bp_count: got %0d expected %0d", count, DEPTH); else n_pass++;
    n_checks++;
    if (imem_addr !== AW'(DEPTH)) $display("FAIL bp_imem_addr: got %0h expected %0h", imem_addr, DEPTH); else n_pass++;
    n_checks++;
    if (deq_pc !== '0) $display("FAIL bp_head: got %0h expected 0", deq_pc); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 0, '0);
      #1;
      e = AW'(k + 1);
      n_checks++;
      if (deq_pc !== e) $display("FAIL bp_drain: got %0h expected %0h", deq_pc, e); else n_pass++;
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    repeat (6) cycle(0, 0, 0, '0);
    cycle(0, 1, 0, '0);
    #1;
    n_checks++;
    if (count !== CW'(DEPTH - 1)) $display("FAIL fullpop_count: got %0d expected %0d", count, DEPTH - 1); else n_pass++;
    n_checks++;
    if (imem_addr !== AW'(DEPTH)) $display("FAIL fullpop_pc_hold: got %0h expected %0h", imem_addr, DEPTH); else n_pass++;
    cycle(0, 0, 0, '0);
    #1;
    n_checks++;
    if (count !== CW'(DEPTH)) $display("FAIL fullpop_refill: got %0d expected %0d", count, DEPTH); else n_pass++;
    n_checks++;
    if (imem_addr !== AW'(DEPTH + 1)) $display("FAIL fullpop_pc_resume: got %0h expected %0h", imem_addr, DEPTH + 1); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) cycle(0, 0, 0, '0);
    #1;
    n_checks++;
    if (count !== CW'(3)) $display("FAIL redir_pre_count: got %0d expected 3", count); else n_pass++;
    cycle(0, 0, 1, AW'(9));
    #1;
    n_checks++;
    if (count !== '0 || deq_valid !== 1'b0) $display("FAIL redir_flush: got count=%0d v=%0b expected 0/0", count, deq_valid); else n_pass++;
    n_checks++;
    if (imem_addr !== AW'(9)) $display("FAIL redir_addr: got %0h expected 9", imem_addr); else n_pass++;
    cycle(0, 1, 0, '0);
    #1;
    n_checks++;
    if (deq_valid !== 1'b1 || deq_pc !== AW'(9)) $display("FAIL redir_first: got v=%0b pc=%0h expected v=1 pc=9", deq_valid, deq_pc); else n_pass++;
  endtask

  task automatic test_redirect_pop();
    do_reset();
    repeat (2) cycle(0, 0, 0, '0);
    cycle(0, 1, 1, AW'(8'h20));
    #1;
    n_checks++;
    if (count !== '0 || deq_valid !== 1'b0 || deq_pc !== '0) $display("FAIL redirpop_flush: got count=%0d v=%0b pc=%0h expected 0/0/0", count, deq_valid, deq_pc); else n_pass++;
    n_checks++;
    if (imem_addr !== AW'(8'h20)) $display("FAIL redirpop_addr: got %0h expected 20", imem_addr); else n_pass++;
    cycle(0, 1, 0, '0);
    #1;
    n_checks++;
    if (deq_pc !== AW'(8'h20) || count !== CW'(1)) $display("FAIL redirpop_first: got pc=%0h count=%0d expected 20/1", deq_pc, count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) cycle(0, 0, 0, '0);
    #1;
    n_checks++;
    if (count !== CW'(2)) $display("FAIL rstmid_pre_count: got %0d expected 2", count); else n_pass++;
    cycle(1, 1, 0, '0);
    #1;
    n_checks++;
    if (count !== '0 || deq_valid !== 1'b0 || deq_pc !== '0 || deq_inst !== '0 || imem_addr !== '0)
      $display("FAIL rstmid_zero: got count=%0d v=%0b pc=%0h inst=%0h addr=%0h expected all 0", count, deq_valid, deq_pc, deq_inst, imem_addr);
    else n_pass++;
    cycle(0, 1, 0, '0);
    #1;
    n_checks++;
    if (deq_valid !== 1'b1 || deq_pc !== '0 || imem_addr !== AW'(1)) $display("FAIL rstmid_restart: got v=%0b pc=%0h addr=%0h expected 1/0/1", deq_valid, deq_pc, imem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] e;
    do_reset();
    cycle(0, 1, 1, AW'(8'hFE));
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, '0);
      #1;
      e = AW'(8'hFE) + AW'(k);
      n_checks++;
      if (deq_pc !== e) $display("FAIL wrap_pc: got %0h expected %0h", deq_pc, e); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit            rdy;
    bit            redir;
    logic [AW-1:0] rpc;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      rdy = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc = AW'($urandom_range(0, 255));
      cycle(0, rdy, redir, rpc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
